// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and ring pointer arithmetic for the fetch prefetch queue
package fetch_pkg;
  localparam int WORD_W = 16;
  localparam int OPC_W = 32;
  localparam int AW_DEF = 16;
  function automatic int unsigned ptr_add(int unsigned ptr, int unsigned n, int unsigned depth);
    return (ptr + n) & (depth - 1);
  endfunction
endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if: core fetch port plus instruction memory read bus
interface fetch_prefetch_queue_if import fetch_pkg::*; #(parameter int AW = AW_DEF) ();
  logic [AW-1:0] i_mem_pc;
  logic [OPC_W-1:0] i_mem_opcode;
  logic i_mem_rdy;
  logic im_req;
  logic [AW-1:0] im_addr;
  logic im_rdy;
  logic [WORD_W-1:0] im_data;
  modport master(input i_mem_pc, im_rdy, im_data, output i_mem_opcode, i_mem_rdy, im_req, im_addr);
  modport slave(output i_mem_pc, im_rdy, im_data, input i_mem_opcode, i_mem_rdy, im_req, im_addr);
endinterface

// File: rtl/fetch_ring.sv
// fetch_ring: DEPTH x 16 word ring, one write port, reads at idx and idx+1
module fetch_ring import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic a_rst,
  input  logic we,
  input  logic [PW-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [PW-1:0] ridx,
  output logic [WORD_W-1:0] rd0,
  output logic [WORD_W-1:0] rd1
);
  logic [WORD_W-1:0] mem [DEPTH];
  // storage cleared on reset so the opcode window is never X
  always_ff @(posedge clk)
    if (a_rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rd0 = mem[ridx];
  assign rd1 = mem[PW'(ptr_add(32'(ridx), 1, DEPTH))];
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential 16-bit prefetch ring feeding the core fetch port; FETCH_STATS_EN adds stat_flush
module fetch_prefetch_queue import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW = AW_DEF
) (
  input  logic clk,
  input  logic a_rst,
`ifdef FETCH_STATS_EN
  output logic [15:0] stat_flush,
`endif
  fetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head, head_n, rd_idx;
  logic [CW-1:0] count, count_d, count_n;
  logic [AW-1:0] base, delta, req_addr, nxt_addr;
  logic pend, stale, hit, wr, pend_after, stale_n, issue;
  logic [WORD_W-1:0] rd0, rd1;
  // drop consumed words, then fill; a miss empties the ring and marks any in-flight read stale
  always_comb begin
    delta = bus.i_mem_pc - base;
    hit = delta <= AW'(count);
    wr = bus.im_rdy & pend & ~stale & hit;
    head_n = hit ? head + delta[PW-1:0] : head;
    count_d = hit ? count - CW'(delta) : '0;
    count_n = count_d + CW'(wr);
    pend_after = pend & ~bus.im_rdy;
    stale_n = pend_after & (stale | ~hit);
    issue = ~pend_after & (count_n < CW'(DEPTH));
    nxt_addr = bus.i_mem_pc + AW'(count_n);
    rd_idx = head + delta[PW-1:0];
  end
  // queue state and the single outstanding request
  always_ff @(posedge clk)
    if (a_rst) begin
      head <= '0;
      count <= '0;
      base <= '0;
      pend <= 1'b0;
      stale <= 1'b0;
      req_addr <= '0;
    end else begin
      head <= head_n;
      count <= count_n;
      base <= bus.i_mem_pc;
      pend <= pend_after | issue;
      stale <= stale_n;
      if (issue) req_addr <= nxt_addr;
    end
`ifdef FETCH_STATS_EN
  // saturating count of flush edges
  always_ff @(posedge clk)
    if (a_rst) stat_flush <= '0;
    else if (~hit && stat_flush != 16'hFFFF) stat_flush <= stat_flush + 16'd1;
`endif
  fetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk(clk),
    .a_rst(a_rst),
    .we(wr),
    .waddr(head_n + count_d[PW-1:0]),
    .wdata(bus.im_data),
    .ridx(rd_idx),
    .rd0(rd0),
    .rd1(rd1)
  );
  assign bus.i_mem_rdy = hit & (count_d >= CW'(2));
  assign bus.i_mem_opcode = {rd1, rd0};
  assign bus.im_req = pend;
  assign bus.im_addr = req_addr;
endmodule
